// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store memory port arbiter.
package mem_arb_pkg;

   // Transaction sequencing: grant in idle, sit out the memory latency, then respond.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } arb_state_e;

   // Owner of the transaction currently in flight.
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   // Byte address bits below the word index.
   localparam int unsigned WORD_OFS = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, grouped as one bus.
// slave is the arbiter's view; master is the view of whatever drives the
// requests and models the memory array.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned MEM_AW = 7
);
   // Instruction fetch requester (read-only).
   logic              i_valid;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ready;
   logic              i_rvalid;
   logic [31:0]       i_rdata;
   logic              i_err;

   // Load/store requester.
   logic              d_valid;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic              d_ready;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic              d_err;

   // Unified memory array.
   logic              mem_en;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  i_valid, i_addr,
      output i_ready, i_rvalid, i_rdata, i_err,
      input  d_valid, d_we, d_addr, d_wdata,
      output d_ready, d_rvalid, d_rdata, d_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output i_valid, i_addr,
      input  i_ready, i_rvalid, i_rdata, i_err,
      output d_valid, d_we, d_addr, d_wdata,
      input  d_ready, d_rvalid, d_rdata, d_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/mem_port_arbiter_prio_select.sv
// Winner selection between fetch and data requesters. Data has fixed priority
// unless fetch has been passed over STARVE_LIM times in a row while waiting.
module arb_prio_select #(
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic grant_en,
   input  logic i_valid,
   input  logic d_valid,
   output logic grant_i,
   output logic grant_d
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIM + 2);
   localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             fetch_first;

   // Pick at most one winner and compute the starvation count after this grant.
   always_comb begin
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      starve_d    = starve_q;
      fetch_first = (starve_q == LIM) && i_valid;
      if (grant_en) begin
         if (d_valid && !fetch_first) begin
            grant_d = 1'b1;
            if (!i_valid) begin
               starve_d = '0;
            end else if (starve_q != LIM) begin
               starve_d = starve_q + CNT_W'(1);
            end
         end else if (i_valid) begin
            grant_i  = 1'b1;
            starve_d = '0;
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported fixed-latency word memory between instruction fetch
// and load/store. One transaction in flight; a grant in idle is followed by
// MEM_LAT-1 wait cycles and one response cycle.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned MEM_AW     = 7,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_LIM = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   arb_state_e        state_q, state_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              owner_q, owner_d;
   logic              err_q, err_d;
   logic              we_q, we_d;

   logic              grant_en, grant_i, grant_d;
   logic [ADDR_W-1:0] win_addr;
   logic              win_we;
   logic              win_oor;

   // Reset is folded in so that nothing handshakes while rst is held low.
   assign grant_en = (state_q == StIdle) && rst;

   arb_prio_select #(
      .STARVE_LIM (STARVE_LIM)
   ) u_prio (
      .clk      (clk),
      .rst      (rst),
      .grant_en (grant_en),
      .i_valid  (bus.i_valid),
      .d_valid  (bus.d_valid),
      .grant_i  (grant_i),
      .grant_d  (grant_d)
   );

   // Request fields of whichever requester wins this cycle.
   always_comb begin
      win_addr = grant_d ? bus.d_addr : bus.i_addr;
      win_we   = grant_d & bus.d_we;
      win_oor  = (win_addr >> (MEM_AW + WORD_OFS)) != '0;
   end

   // Next-state logic plus all handshake and memory outputs.
   always_comb begin
      state_d       = state_q;
      lat_d         = lat_q;
      owner_d       = owner_q;
      err_d         = err_q;
      we_d          = we_q;
      bus.i_ready   = 1'b0;
      bus.i_rvalid  = 1'b0;
      bus.i_rdata   = '0;
      bus.i_err     = 1'b0;
      bus.d_ready   = 1'b0;
      bus.d_rvalid  = 1'b0;
      bus.d_rdata   = '0;
      bus.d_err     = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;

      unique case (state_q)
         StIdle: begin
            if (grant_i || grant_d) begin
               bus.i_ready   = grant_i;
               bus.d_ready   = grant_d;
               // Out-of-range accesses still take a slot but never touch memory.
               bus.mem_en    = !win_oor;
               bus.mem_we    = win_we && !win_oor;
               bus.mem_addr  = win_addr[MEM_AW+WORD_OFS-1:WORD_OFS];
               bus.mem_wdata = win_we ? bus.d_wdata : '0;
               owner_d       = grant_d ? OWN_D : OWN_I;
               err_d         = win_oor;
               we_d          = win_we;
               lat_d         = LAT_W'(MEM_LAT - 1);
               state_d       = (MEM_LAT == 1) ? StResp : StWait;
            end
         end
         StWait: begin
            lat_d = lat_q - LAT_W'(1);
            if (lat_q == LAT_W'(1)) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (owner_q == OWN_D) begin
               bus.d_rvalid = 1'b1;
               bus.d_err    = err_q;
               bus.d_rdata  = (err_q || we_q) ? '0 : bus.mem_rdata;
            end else begin
               bus.i_rvalid = 1'b1;
               bus.i_err    = err_q;
               bus.i_rdata  = err_q ? '0 : bus.mem_rdata;
            end
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Transaction state registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         lat_q   <= '0;
         owner_q <= OWN_I;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         owner_q <= owner_d;
         err_q   <= err_d;
         we_q    <= we_d;
      end
   end

endmodule
